// File: rtl/snake_collision_check.sv
// Collision judge for the snake controller: checks the new head for wall, food and body hits.
// Scans segment memory one address per cycle; the read port has one cycle of latency.
module snake_collision_check #(
  parameter int unsigned X_MAX = 160,
  parameter int unsigned Y_MAX = 120,
  parameter int unsigned LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       head_x,
  input  logic [6:0]       head_y,
  input  logic [7:0]       food_x,
  input  logic [6:0]       food_y,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  input  logic             clr_dead,
  output logic [LEN_W-1:0] rd_addr,
  output logic             busy,
  output logic             done,
  output logic             length_inc,
  output logic             new_food_req,
  output logic             is_dead
);

  typedef enum logic [2:0] {StIdle, StCheck, StScan, StDrain, StDone} state_e;

  localparam logic [LEN_W:0] One = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] Two = (LEN_W+1)'(2);

  state_e           state_q;
  logic [7:0]       hx_q, fx_q;
  logic [6:0]       hy_q, fy_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] scan_last_q;
  logic             ate_q;
  logic             dead_pend_q;
  logic             issue_q;

  logic             wall;
  logic             ate_c;
  logic             hit;
  logic [LEN_W:0]   last_ext;

  always_comb begin
    wall     = (32'(hx_q) >= X_MAX) || (32'(hy_q) >= Y_MAX);
    ate_c    = (hx_q == fx_q) && (hy_q == fy_q);
    // Tail leaves its cell unless the snake grows; MSB set means nothing to scan.
    last_ext = {1'b0, len_q} - (ate_c ? One : Two);
    hit      = issue_q && (rd_x == hx_q) && (rd_y == hy_q);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      hx_q         <= '0;
      hy_q         <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      len_q        <= '0;
      scan_last_q  <= '0;
      ate_q        <= 1'b0;
      dead_pend_q  <= 1'b0;
      issue_q      <= 1'b0;
      rd_addr      <= '0;
      done         <= 1'b0;
      length_inc   <= 1'b0;
      new_food_req <= 1'b0;
      is_dead      <= 1'b0;
    end else begin
      issue_q      <= (state_q == StScan);
      done         <= 1'b0;
      length_inc   <= 1'b0;
      new_food_req <= 1'b0;
      if (state_q != StDone && clr_dead) is_dead <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start) begin
            hx_q        <= head_x;
            hy_q        <= head_y;
            fx_q        <= food_x;
            fy_q        <= food_y;
            len_q       <= length;
            ate_q       <= 1'b0;
            dead_pend_q <= 1'b0;
            state_q     <= StCheck;
          end
        end
        StCheck: begin
          if (wall) begin
            dead_pend_q <= 1'b1;
            ate_q       <= 1'b0;
            done        <= 1'b1;
            state_q     <= StDone;
          end else begin
            ate_q       <= ate_c;
            scan_last_q <= last_ext[LEN_W-1:0];
            rd_addr     <= '0;
            if (last_ext[LEN_W]) begin
              done         <= 1'b1;
              length_inc   <= ate_c;
              new_food_req <= ate_c;
              state_q      <= StDone;
            end else begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (hit) begin
            dead_pend_q <= 1'b1;
            done        <= 1'b1;
            state_q     <= StDone;
          end else if (rd_addr == scan_last_q) begin
            state_q <= StDrain;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        StDrain: begin
          done    <= 1'b1;
          state_q <= StDone;
          if (hit) begin
            dead_pend_q <= 1'b1;
          end else begin
            length_inc   <= ate_q;
            new_food_req <= ate_q;
          end
        end
        StDone: begin
          // A death verdict overrides a simultaneous clear.
          is_dead <= dead_pend_q | (is_dead & ~clr_dead);
          rd_addr <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/snake_collision_check.md
Name: snake_collision_check

Overview:
Judging stage for the snake movement controller. Runs each time the head has been updated, after the controller's length-check strobe. Decides whether the new head hit a wall, ate the food, or ran into its own body. Scans the segment memory through a read port with one cycle of latency, then returns the length-increment pulse and the sticky death flag that the controller consumes.

Parameters:
X_MAX, 160, playfield width in x units; a head x >= X_MAX is a wall hit
Y_MAX, 120, playfield height in y units; a head y >= Y_MAX is a wall hit
LEN_W, 11, width of the length and segment address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle strobe, driven by the controller's length-check output
head_x  in  8  x of the updated head
head_y  in  7  y of the updated head
food_x  in  8  current food x
food_y  in  7  current food y
length  in  LEN_W  current snake length in segments
rd_x  in  8  segment memory x data, valid one cycle after rd_addr
rd_y  in  7  segment memory y data, valid one cycle after rd_addr
clr_dead  in  1  clears is_dead; driven when the black-screen pass completes
rd_addr  out  LEN_W  segment memory read address
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the verdict is final
length_inc  out  1  one-cycle pulse, coincident with done, when food was eaten and the head survived
new_food_req  out  1  one-cycle pulse, coincident with length_inc
is_dead  out  1  sticky death flag

Behaviour:
- Reset:
  - Values: all outputs 0, rd_addr 0, state IDLE.
  - Reset mid-scan abandons the scan; no done is produced.
- States: IDLE, CHECK, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 latches head_x, head_y, food_x, food_y and length; next state CHECK.
  - start in any other state is ignored.
- CHECK (1 cycle):
  - wall = (head_x >= X_MAX) or (head_y >= Y_MAX), unsigned compare. Underflowed coordinates therefore register as wall hits.
  - ate = head equals food.
  - wall=1: set dead_pend and go to DONE; ate is forced to 0.
  - Otherwise scan_last = ate ? length-1 : length-2. The tail vacates its cell unless the snake grows.
  - If length-2 would be negative (length <= 1 and not ate), go straight to DONE.
  - Otherwise set rd_addr = 0 and go to SCAN.
- SCAN:
  - Issue one address per cycle: rd_addr increments each cycle.
  - A compare-valid flag is the address-issue flag delayed by one cycle.
  - When valid and {rd_x, rd_y} equal the latched head: set dead_pend, go to DONE immediately, stop issuing addresses.
  - When rd_addr == scan_last is issued, go to DRAIN.
- DRAIN (1 cycle): final compare for the last address; then go to DONE.
- DONE (1 cycle):
  - done = 1.
  - is_dead is set if dead_pend.
  - length_inc = new_food_req = ate & ~dead_pend.
  - Then return to IDLE, rd_addr 0.
- Latency from the start cycle to done:
  - wall hit: 2 cycles
  - no food: length+2 cycles
  - food eaten: length+3 cycles
  - self hit at address k: k+4 cycles
- is_dead:
  - Holds until clr_dead=1, which clears it on the next edge.
  - If clr_dead and a death verdict in DONE occur in the same cycle, set wins.
  - is_dead does not block a new start.
- Arithmetic:
  - Equality compares use full widths.
  - length and rd_addr are unsigned LEN_W wide.
  - scan_last is computed in LEN_W+1 bits so the length <= 1 case is detectable.

Test Plan:
1. length=3, head (10,10), food (50,50), memory {(12,10),(14,10),(16,10)}, start -> rd_addr 0,1; done 5 cycles after start; length_inc=0; is_dead=0.
2. Same memory, food (10,10), start -> rd_addr 0,1,2; done at cycle 6; length_inc=new_food_req=1 for exactly one cycle.
3. head_x=160 (=X_MAX), start -> done at cycle 2; no rd_addr activity; is_dead=1; is_dead stays high until clr_dead is pulsed, then reads 0 on the next cycle.
4. length=5, memory address 1 = head -> scan aborts after address 2 is issued; done at cycle 5; is_dead=1; length_inc=0 even with food on the head.
5. Tail-vacate check: length=3, address 2 = head, no food -> is_dead=0; repeat with food on the head -> is_dead=1, length_inc=0.
6. Assert rst low during SCAN, then start again -> outputs read 0 immediately; no done from the aborted run; the new run completes normally. A start pulse while busy produces no effect.
